// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: RV32I width codes,
// FSM states and response codes.
package lsu_pkg;

    localparam int LSU_XLEN = 32;
    localparam int LSU_BE_W = LSU_XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        RESP_OK       = 2'b00,
        RESP_MISALIGN = 2'b01,
        RESP_ILLEGAL  = 2'b10
    } resp_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: byte enables, store-data
// replication, load extraction/extension and legality/alignment flags.
module lsu_align
    import lsu_pkg::*;
(
    input  logic                store_i,
    input  logic [2:0]          funct3_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [LSU_XLEN-1:0] wdata_i,
    input  logic [LSU_XLEN-1:0] rdata_i,
    output logic [LSU_BE_W-1:0] be_o,
    output logic [LSU_XLEN-1:0] wdata_o,
    output logic [LSU_XLEN-1:0] load_data_o,
    output logic                illegal_o,
    output logic                misalign_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        be_o        = '0;
        wdata_o     = '0;
        load_data_o = '0;
        illegal_o   = 1'b0;
        misalign_o  = 1'b0;

        unique case (funct3_i)
            F3_B, F3_BU: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_o     = {4{wdata_i[7:0]}};
                load_data_o = (funct3_i == F3_B) ? {{24{byte_lane[7]}}, byte_lane}
                                                 : {24'b0, byte_lane};
            end
            F3_H, F3_HU: begin
                be_o        = 4'b0011 << addr_lo_i;
                wdata_o     = {2{wdata_i[15:0]}};
                load_data_o = (funct3_i == F3_H) ? {{16{half_lane[15]}}, half_lane}
                                                 : {16'b0, half_lane};
                misalign_o  = addr_lo_i[0];
            end
            F3_W: begin
                be_o        = 4'b1111;
                wdata_o     = wdata_i;
                load_data_o = rdata_i;
                misalign_o  = (addr_lo_i != 2'b00);
            end
            default: illegal_o = 1'b1;
        endcase

        // Stores have no unsigned variants.
        if (store_i && funct3_i[2]) begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one op from execute, runs a single-outstanding
// req/ack transaction to data memory and returns the result to writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN,
    parameter int BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            op_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic [1:0]      resp_err
);

    state_t          state_q,     state_d;
    logic            op_store_q,  op_store_d;
    logic [2:0]      funct3_q,    funct3_d;
    logic [XLEN-1:0] addr_q,      addr_d;
    logic [XLEN-1:0] wdata_q,     wdata_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    resp_t           resp_err_q,  resp_err_d;

    logic            in_idle;
    logic            al_store;
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr_lo;
    logic [XLEN-1:0] al_wdata;
    logic [BE_W-1:0] al_be;
    logic [XLEN-1:0] al_wdata_sh;
    logic [XLEN-1:0] al_load_data;
    logic            al_illegal;
    logic            al_misalign;

    // In IDLE the live request is checked; afterwards the latched copy drives the bus.
    assign in_idle    = (state_q == IDLE);
    assign al_store   = in_idle ? op_store   : op_store_q;
    assign al_funct3  = in_idle ? funct3     : funct3_q;
    assign al_addr_lo = in_idle ? addr[1:0]  : addr_q[1:0];
    assign al_wdata   = in_idle ? wdata      : wdata_q;

    lsu_align u_align (
        .store_i     (al_store),
        .funct3_i    (al_funct3),
        .addr_lo_i   (al_addr_lo),
        .wdata_i     (al_wdata),
        .rdata_i     (mem_rdata),
        .be_o        (al_be),
        .wdata_o     (al_wdata_sh),
        .load_data_o (al_load_data),
        .illegal_o   (al_illegal),
        .misalign_o  (al_misalign)
    );

    always_comb begin
        state_d     = state_q;
        op_store_d  = op_store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_store_d  = op_store;
                    funct3_d    = funct3;
                    addr_d      = addr;
                    wdata_d     = wdata;
                    resp_data_d = '0;
                    resp_err_d  = RESP_OK;
                    if (al_illegal) begin
                        resp_err_d = RESP_ILLEGAL;
                        state_d    = RESP;
                    end else if (al_misalign) begin
                        resp_err_d = RESP_MISALIGN;
                        state_d    = RESP;
                    end else begin
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    resp_data_d = op_store_q ? '0 : al_load_data;
                    resp_err_d  = RESP_OK;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_store_q  <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= RESP_OK;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            op_store_q  <= op_store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Bus outputs are decoded from registered state, so they are stable for the whole REQ.
    assign req_ready  = in_idle;
    assign mem_req    = (state_q == REQ);
    assign mem_we     = mem_req & op_store_q;
    assign mem_addr   = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_be     = mem_req ? al_be : '0;
    assign mem_wdata  = mem_req ? al_wdata_sh : '0;
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed vectors.
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        op_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int accept_cnt = 0;

    load_store_unit #(.XLEN(32), .BE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_store   (op_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && req_valid && req_ready) accept_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        op_store = ~op_store;
        funct3   = 3'b111;
        addr     = 32'hFFFF_FFFF;
        wdata    = 32'h1234_5678;
    endtask

    // Full bus transaction; ack_wait idle REQ cycles precede the ack.
    task automatic mem_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int ack_wait,
                          input logic [31:0] rd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_data);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; op_store = st; funct3 = f3; addr = a; wdata = wd;
        tick();
        req_valid = 1'b0;
        scramble_inputs();
        check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
        check({tag, ".mem_we"}, 32'(mem_we), 32'(st));
        check({tag, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
        check({tag, ".mem_be"}, 32'(mem_be), 32'(exp_be));
        check({tag, ".busy"}, 32'(req_ready), 32'd0);
        if (st) check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
        for (int i = 0; i < ack_wait; i++) begin
            tick();
            check({tag, ".hold_req"}, 32'(mem_req), 32'd1);
            check({tag, ".hold_be"}, 32'(mem_be), 32'(exp_be));
            check({tag, ".early_resp"}, 32'(resp_valid), 32'd0);
        end
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_data"}, resp_data, exp_data);
        check({tag, ".resp_err"}, 32'(resp_err), 32'(RESP_OK));
        check({tag, ".req_dropped"}, 32'(mem_req), 32'd0);
        check({tag, ".resp_busy"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
        check({tag, ".idle"}, 32'(req_ready), 32'd1);
    endtask

    // Op rejected at accept: response at N+1 and the bus stays quiet.
    task automatic err_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [1:0] exp_err);
        req_valid = 1'b1; op_store = st; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        scramble_inputs();
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_err"}, 32'(resp_err), 32'(exp_err));
        check({tag, ".resp_data"}, resp_data, 32'd0);
        check({tag, ".no_mem_req"}, 32'(mem_req), 32'd0);
        tick();
        check({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
        check({tag, ".no_mem_req2"}, 32'(mem_req), 32'd0);
        check({tag, ".idle"}, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int budget;
        budget = 20;
        while (!req_ready && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, ".ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int acc_base;

        #2;
        check("rst.mem_req",    32'(mem_req),    32'd0);
        check("rst.mem_we",     32'(mem_we),     32'd0);
        check("rst.mem_be",     32'(mem_be),     32'd0);
        check("rst.mem_addr",   mem_addr,        32'd0);
        check("rst.mem_wdata",  mem_wdata,       32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_data",  resp_data,       32'd0);
        check("rst.resp_err",   32'(resp_err),   32'd0);
        tick();
        tick();
        reset = 1'b1;
        check("rst.ready", 32'(req_ready), 32'd1);
        tick();

        mem_op("sw",  1'b1, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0,
               4'b1111, 32'hDEAD_BEEF, 32'h0);
        mem_op("lb",  1'b0, F3_B,  32'h0000_0203, 32'h0, 1, 32'h8011_2233,
               4'b1000, 32'h0, 32'hFFFF_FF80);
        mem_op("lbu", 1'b0, F3_BU, 32'h0000_0203, 32'h0, 0, 32'h8011_2233,
               4'b1000, 32'h0, 32'h0000_0080);
        mem_op("lh",  1'b0, F3_H,  32'h0000_0302, 32'h0, 0, 32'h7FFF_0000,
               4'b1100, 32'h0, 32'h0000_7FFF);
        mem_op("lh0", 1'b0, F3_H,  32'h0000_0000, 32'h0, 1, 32'h1234_F00D,
               4'b0011, 32'h0, 32'hFFFF_F00D);
        mem_op("lhu", 1'b0, F3_HU, 32'h0000_0000, 32'h0, 0, 32'h1234_F00D,
               4'b0011, 32'h0, 32'h0000_F00D);
        mem_op("lw",  1'b0, F3_W,  32'h0000_0010, 32'h0, 3, 32'hCAFE_F00D,
               4'b1111, 32'h0, 32'hCAFE_F00D);
        mem_op("sb",  1'b1, F3_B,  32'h0000_0001, 32'h0000_00A5, 0, 32'hFFFF_FFFF,
               4'b0010, 32'hA5A5_A5A5, 32'h0);

        err_op("lw_mis",   1'b0, F3_W,   32'h0000_0302, RESP_MISALIGN);
        err_op("sh_mis",   1'b1, F3_H,   32'h0000_0001, RESP_MISALIGN);
        err_op("ld_ill",   1'b0, 3'b011, 32'h0000_0000, RESP_ILLEGAL);
        err_op("st_ill",   1'b1, 3'b100, 32'h0000_0000, RESP_ILLEGAL);
        err_op("ill_prio", 1'b0, 3'b111, 32'h0000_0003, RESP_ILLEGAL);

        // Stray ack while idle must be ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check("stray.resp_valid", 32'(resp_valid), 32'd0);
        check("stray.ready",      32'(req_ready),  32'd1);

        // SH with req_valid held high: one accept per IDLE visit.
        acc_base = accept_cnt;
        req_valid = 1'b1; op_store = 1'b1; funct3 = F3_H;
        addr = 32'h0000_0402; wdata = 32'h0000_ABCD;
        tick();
        check("sh.mem_be",    32'(mem_be),    32'h0000_000C);
        check("sh.mem_wdata", mem_wdata,      32'hABCD_ABCD);
        check("sh.mem_addr",  mem_addr,       32'h0000_0400);
        check("sh.req_busy",  32'(req_ready), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sh.resp_valid", 32'(resp_valid), 32'd1);
        check("sh.resp_busy",  32'(req_ready),  32'd0);
        check("sh.accepts1",   accept_cnt - acc_base, 32'd1);
        tick();
        check("sh.idle",       32'(req_ready),  32'd1);
        check("sh.accepts1b",  accept_cnt - acc_base, 32'd1);
        tick();
        req_valid = 1'b0;
        check("sh.accepts2",   accept_cnt - acc_base, 32'd2);
        check("sh.req2",       32'(mem_req),    32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sh.resp2",      32'(resp_valid), 32'd1);
        tick();
        wait_ready("sh");

        // Reset mid-REQ with ack withheld.
        req_valid = 1'b1; op_store = 1'b0; funct3 = F3_W; addr = 32'h0000_0500;
        tick();
        req_valid = 1'b0;
        check("rmid.mem_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rmid.req_drop",   32'(mem_req),    32'd0);
        check("rmid.be_drop",    32'(mem_be),     32'd0);
        check("rmid.no_resp",    32'(resp_valid), 32'd0);
        tick();
        check("rmid.no_resp2",   32'(resp_valid), 32'd0);
        reset = 1'b1;
        check("rmid.ready",      32'(req_ready),  32'd1);
        tick();
        check("rmid.no_resp3",   32'(resp_valid), 32'd0);
        check("rmid.idle_req",   32'(mem_req),    32'd0);
        mem_op("lw_post", 1'b0, F3_W, 32'h0000_0504, 32'h0, 1, 32'h0BAD_CAFE,
               4'b1111, 32'h0, 32'h0BAD_CAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
